// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the instruction/data memory arbiter.
// Imported by mem_arbiter and by the Mips sources that instantiate it.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned MAX_WAIT_DEF   = 4;
    localparam int unsigned BE_WIDTH       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single Ram port. Data wins ties
// unless the fetch side has lost MAX_WAIT consecutive ties, then fetch goes first.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_WAIT   = MAX_WAIT_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [BE_WIDTH-1:0]   d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  m_req,
    output logic                  m_we,
    output logic [BE_WIDTH-1:0]   m_be,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ready
);

    localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    arb_state_e            state_q, state_d;
    logic                  gnt_d_q, gnt_d_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  starved;

    assign starved = (wait_cnt_q == WCW'(MAX_WAIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (d_req && !(i_req && starved)) begin
                    state_d = ST_GRANT_D;
                end else if (i_req) begin
                    state_d = ST_GRANT_I;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (m_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (state_q == ST_GRANT_I || state_q == ST_GRANT_D) begin
            m_req   = 1'b1;
            m_we    = we_q;
            m_be    = be_q;
            m_addr  = addr_q;
            m_wdata = wdata_q;
        end
        i_ack = (state_q == ST_RESP) && !gnt_d_q;
        d_ack = (state_q == ST_RESP) && gnt_d_q;
    end

    // Operands are latched on the IDLE->GRANT edge so requesters may drop req mid-grant.
    always_comb begin
        gnt_d_d    = gnt_d_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (state_q == ST_IDLE && state_d == ST_GRANT_D) begin
            gnt_d_d = 1'b1;
            addr_d  = d_addr;
            we_d    = d_we;
            be_d    = d_be;
            wdata_d = d_wdata;
            if (i_req && !starved) begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
            end
        end
        if (state_q == ST_IDLE && state_d == ST_GRANT_I) begin
            gnt_d_d    = 1'b0;
            addr_d     = i_addr;
            we_d       = 1'b0;
            be_d       = '1;
            wdata_d    = '0;
            wait_cnt_d = '0;
        end
        if (state_q == ST_GRANT_I && m_ready) begin
            i_rdata_d = m_rdata;
        end
        if (state_q == ST_GRANT_D && m_ready && !we_q) begin
            d_rdata_d = m_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_d_q    <= 1'b0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            gnt_d_q    <= gnt_d_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for starvation, reset mid-grant and dropped requests.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned ack_overlap = 0;

    mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_WAIT  (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_rdata(i_rdata),
        .i_ack  (i_ack),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_be   (d_be),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ack  (d_ack),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_be   (m_be),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ready(m_ready)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (i_ack && d_ack) ack_overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned delay;
        logic [31:0] ram;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_i_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input int unsigned idx, input vec_t v);
        m_ready = 1'b0;
        m_rdata = 32'h0;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
            i_req = 1'b0; i_addr = 32'hFFFF_FFF0;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
            d_req = 1'b0; d_we = 1'b1; d_be = 4'h5; d_addr = 32'hFFFF_FFF0; d_wdata = 32'h5555_5555;
        end
        step();
        for (int unsigned k = 1; k <= v.delay; k++) begin
            check($sformatf("v%0d m_req grant c%0d", idx, k), 64'(m_req), 64'(1'b1));
            check($sformatf("v%0d m_addr c%0d", idx, k), 64'(m_addr), 64'(v.addr));
            check($sformatf("v%0d m_be c%0d", idx, k), 64'(m_be), 64'(v.exp_be));
            check($sformatf("v%0d m_we c%0d", idx, k), 64'(m_we), 64'(v.exp_we));
            if (v.is_d) check($sformatf("v%0d m_wdata c%0d", idx, k), 64'(m_wdata), 64'(v.wdata));
            check($sformatf("v%0d acks idle c%0d", idx, k), 64'({i_ack, d_ack}), 64'(2'b00));
            if (k == v.delay) begin
                m_ready = 1'b1;
                m_rdata = v.ram;
            end
            step();
        end
        m_ready = 1'b0;
        m_rdata = 32'h0;
        i_req = 1'b0;
        d_req = 1'b0;
        check($sformatf("v%0d m_req resp", idx), 64'(m_req), 64'(1'b0));
        check($sformatf("v%0d i_ack resp", idx), 64'(i_ack), 64'(!v.is_d));
        check($sformatf("v%0d d_ack resp", idx), 64'(d_ack), 64'(v.is_d));
        check($sformatf("v%0d i_rdata", idx), 64'(i_rdata), 64'(v.exp_i_rdata));
        check($sformatf("v%0d d_rdata", idx), 64'(d_rdata), 64'(v.exp_d_rdata));
        step();
        check($sformatf("v%0d acks after", idx), 64'({i_ack, d_ack}), 64'(2'b00));
    endtask

    initial begin
        logic exp_is_d [10];
        int unsigned c;
        logic act_is_d;

        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0;

        //              is_d we  be     addr          wdata          dly ram            ebe    ewe  exp_i_rdata    exp_d_rdata
        vecs[0] = '{1'b1, 1'b1, 4'b0011, 32'h10, 32'hDEAD_BEEF, 2, 32'h1111_1111, 4'b0011, 1'b1, 32'h0,          32'h0};
        vecs[1] = '{1'b0, 1'b0, 4'b0000, 32'h00, 32'h0,         1, 32'h2008_0003, 4'b1111, 1'b0, 32'h2008_0003, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 4'b1100, 32'h24, 32'h0,         3, 32'hCAFE_F00D, 4'b1100, 1'b0, 32'h2008_0003, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 1'b1, 4'b1111, 32'h28, 32'h1234_5678, 1, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h2008_0003, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 4'b0000, 32'h40, 32'h0,         2, 32'hA5A5_A5A5, 4'b1111, 1'b0, 32'hA5A5_A5A5, 32'hCAFE_F00D};

        step();
        step();
        check("reset state", 64'(dut.state_q), 64'(ST_IDLE));
        check("reset m_req", 64'(m_req), 64'(0));
        check("reset m_we/m_be", 64'({m_we, m_be}), 64'(0));
        check("reset m_addr", 64'(m_addr), 64'(0));
        check("reset m_wdata", 64'(m_wdata), 64'(0));
        check("reset acks", 64'({i_ack, d_ack}), 64'(0));
        check("reset i_rdata", 64'(i_rdata), 64'(0));
        check("reset d_rdata", 64'(d_rdata), 64'(0));
        check("reset wait_cnt", 64'(dut.wait_cnt_q), 64'(0));
        reset = 1'b0;
        step();

        for (int unsigned i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // m_ready pulsed while idle must be ignored
        m_ready = 1'b1; m_rdata = 32'h7777_7777;
        step();
        m_ready = 1'b0;
        check("idle ready state", 64'(dut.state_q), 64'(ST_IDLE));
        check("idle ready acks", 64'({i_ack, d_ack}), 64'(0));
        step();
        check("idle ready i_rdata", 64'(i_rdata), 64'(32'hA5A5_A5A5));
        check("idle ready d_rdata", 64'(d_rdata), 64'(32'hCAFE_F00D));

        // d_req dropped during GRANT_D still completes with one ack
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h30;
        step();
        d_req = 1'b0; d_addr = 32'h0;
        check("drop grant m_addr", 64'(m_addr), 64'(32'h30));
        step();
        check("drop still granted", 64'(m_req), 64'(1));
        m_ready = 1'b1; m_rdata = 32'h0BAD_F00D;
        step();
        m_ready = 1'b0;
        check("drop d_ack", 64'(d_ack), 64'(1));
        check("drop d_rdata", 64'(d_rdata), 64'(32'h0BAD_F00D));
        step();
        check("drop d_ack once", 64'(d_ack), 64'(0));
        step();
        check("drop stays idle", 64'(m_req), 64'(0));

        // Both requesters held: four data grants then one forced fetch, twice
        exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
        for (int unsigned g = 0; g < 10; g++) begin
            c = 0;
            while (!m_req && c < 8) begin
                step();
                c++;
            end
            if (!m_req) begin
                check($sformatf("starve g%0d grant timeout", g), 64'(m_req), 64'(1));
                break;
            end
            act_is_d = (m_addr == 32'h200);
            check($sformatf("starve g%0d order", g), 64'(act_is_d), 64'(exp_is_d[g]));
            if (!exp_is_d[g]) check($sformatf("starve g%0d wait_cnt clr", g), 64'(dut.wait_cnt_q), 64'(0));
            if (g == 3 || g == 8) check($sformatf("starve g%0d wait_cnt sat", g), 64'(dut.wait_cnt_q), 64'(4));
            m_ready = 1'b1; m_rdata = 32'h1000 + g;
            step();
            m_ready = 1'b0;
            check($sformatf("starve g%0d ack", g), 64'({i_ack, d_ack}),
                  exp_is_d[g] ? 64'(2'b01) : 64'(2'b10));
            if (exp_is_d[g]) check($sformatf("starve g%0d d_rdata", g), 64'(d_rdata), 64'(32'h1000 + g));
            else             check($sformatf("starve g%0d i_rdata", g), 64'(i_rdata), 64'(32'h1000 + g));
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        step();

        // Reset during GRANT_D abandons the transaction
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h50; d_wdata = 32'h0;
        step();
        check("rst grant m_req", 64'(m_req), 64'(1));
        reset = 1'b1; d_req = 1'b0;
        step();
        reset = 1'b0;
        check("rst mid m_req", 64'(m_req), 64'(0));
        check("rst mid state", 64'(dut.state_q), 64'(ST_IDLE));
        check("rst mid acks", 64'({i_ack, d_ack}), 64'(0));
        check("rst mid d_rdata", 64'(d_rdata), 64'(0));
        m_ready = 1'b1; m_rdata = 32'h9999_9999;
        step();
        m_ready = 1'b0;
        check("rst ready ignored", 64'(dut.state_q), 64'(ST_IDLE));
        check("rst ready acks", 64'({i_ack, d_ack}), 64'(0));
        i_req = 1'b1; i_addr = 32'h8;
        step();
        check("rst then i m_addr", 64'(m_addr), 64'(32'h8));
        check("rst then i m_be", 64'(m_be), 64'(4'hF));
        m_ready = 1'b1; m_rdata = 32'h4242_4242;
        step();
        m_ready = 1'b0; i_req = 1'b0;
        check("rst then i_ack", 64'({i_ack, d_ack}), 64'(2'b10));
        check("rst then i_rdata", 64'(i_rdata), 64'(32'h4242_4242));
        step();
        check("rst then idle", 64'({i_ack, d_ack, m_req}), 64'(0));

        check("acks never together", 64'(ack_overlap), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; MAX_WAIT, 4, consecutive data grants before a waiting fetch is forced through.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR_WIDTH  fetch address
- i_rdata  out  DATA_WIDTH  fetch read data
- i_ack  out  1  fetch completion pulse
- d_req  in  1  data-stage request
- d_we  in  1  data write enable
- d_be  in  4  data byte enables
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  data write value
- d_rdata  out  DATA_WIDTH  data read data
- d_ack  out  1  data completion pulse
- m_req  out  1  Ram request
- m_we  out  1  Ram write enable
- m_be  out  4  Ram byte enables
- m_addr  out  ADDR_WIDTH  Ram address
- m_wdata  out  DATA_WIDTH  Ram write value
- m_rdata  in  DATA_WIDTH  Ram read data
- m_ready  in  1  Ram completion, one or more cycles after m_req

Function
REQ-004 The FSM SHALL have the states IDLE, GRANT_I, GRANT_D and RESP.
REQ-005 In IDLE, the grant SHALL be chosen as follows:
- d_req only -> GRANT_D.
- i_req only -> GRANT_I.
- Both asserted -> GRANT_D, unless wait_cnt == MAX_WAIT, in which case -> GRANT_I.
- Neither asserted -> stay in IDLE.
REQ-006 On entry to a GRANT state, the requester's addr, we, be and wdata SHALL be latched. m_req SHALL be 1 and the m_* outputs SHALL be driven from the latched values for the whole GRANT state.
REQ-007 GRANT_I SHALL drive m_we=0 and m_be=4'b1111.
REQ-008 In GRANT_x, m_ready=1 SHALL capture m_rdata into x_rdata and move the FSM to RESP. While m_ready=0 the FSM SHALL hold.
REQ-009 RESP SHALL pulse x_ack for exactly one cycle, for the granted requester only, and then return to IDLE. m_req SHALL be 0 in RESP.
REQ-010 x_rdata SHALL hold its value until the next completed read for that requester. Writes SHALL leave d_rdata unchanged.
REQ-011 Minimum latency SHALL be 3 cycles from request sampled in IDLE to ack (m_ready in the first GRANT cycle).
REQ-012 Requesters hold req and operands stable until ack. A req held high in the cycle after ack SHALL be treated as a new request.
REQ-013 If req is dropped during GRANT, the transaction SHALL still complete and ack SHALL still pulse.
REQ-014 m_ready SHALL be ignored in IDLE and RESP.
REQ-015 wait_cnt (saturating at MAX_WAIT) SHALL be updated as follows:
- Increment on each GRANT_D entry while i_req=1.
- Clear on GRANT_I entry.
- Otherwise unchanged.
REQ-016 i_ack and d_ack SHALL never be asserted in the same cycle. m_req SHALL never serve both requesters at once.

Reset
REQ-017 With reset=1 at a clock edge, the following SHALL hold on the next cycle, regardless of state:
- state=IDLE.
- m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0.
- i_ack=0, d_ack=0.
- i_rdata=0, d_rdata=0.
- wait_cnt=0.
REQ-018 A Ram transaction in flight at reset SHALL be abandoned without ack. m_ready in the cycle after reset SHALL be ignored.

Structure
REQ-019 The state encodings, MAX_WAIT default and widths SHALL live in the shared include header used by the Mips sources.
REQ-020 The block SHALL instantiate no sub-module. The starvation counter is inline; Mips instantiates mem_arbiter between Fetch/Memory and Ram.

Verification
REQ-021 Reset, then d_req=1 with d_we=1, d_be=4'b0011, d_addr=0x10, d_wdata=0xDEADBEEF, and Ram ready after 2 cycles -> m_req=1 for 2 cycles with m_addr=0x10 and m_be=0011, then d_ack for 1 cycle; i_ack stays 0.
REQ-022 i_req with i_addr=0x0, Ram returns 0x20080003 on the first GRANT cycle -> i_ack on cycle 3 with i_rdata=0x20080003.
REQ-023 i_req and d_req held continuously with MAX_WAIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; wait_cnt returns to 0 after each I grant.
REQ-024 reset asserted during GRANT_D with m_ready=0 -> next cycle m_req=0 and state IDLE; no ack pulses; a following i_req is served normally.
REQ-025 m_ready pulsed in IDLE with no requests -> no state change, no ack, rdata unchanged.
REQ-026 d_req dropped mid-GRANT_D -> d_ack still pulses once when m_ready arrives.
